// File: rtl/const_div_iter.sv
// ---------------------------------------------------------------------------
// const_div_iter
//
// Divides an unsigned W-bit operand by the compile-time constant D and returns
// quotient and remainder. The divider is digit-serial: each RUN cycle retires
// K dividend bits (MSB chunk first) through a small combinational divide of a
// (RW+K)-bit partial value by D, so datapath width follows K rather than W.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand valid
//   in_ready   block can accept an operand this cycle
//   in_x       unsigned dividend, W bits
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts result
//   out_q      quotient floor(in_x / D), QW bits
//   out_r      remainder in_x mod D, RW bits
//
// Handshake: IDLE accepts an operand; RUN takes NSTEP cycles; DONE presents
// the result. In DONE, in_ready follows out_ready so a consumed result and a
// new operand can be exchanged on the same edge with no bubble.
// ---------------------------------------------------------------------------
module const_div_iter #(
    parameter int W     = 64,
    parameter int D     = 23,
    parameter int K     = 4,
    parameter int QW    = W - $clog2(D + 1) + 1,
    parameter int RW    = $clog2(D),
    parameter int NSTEP = (W + K - 1) / K
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] out_q,
    output logic [RW-1:0] out_r
);

    // Operand is zero-extended at the MSB so it splits into whole K-bit chunks.
    localparam int PW = NSTEP * K;
    // Partial value r*2^K + chunk is below D*2^K, so RW+K bits always suffice.
    localparam int TW = RW + K;
    localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    generate
        if (D < 2 || D > 65535) begin : g_bad_d
            $error("const_div_iter: D=%0d outside legal range 2..65535", D);
        end
        if (K < 1 || K > W) begin : g_bad_k
            $error("const_div_iter: K=%0d outside legal range 1..W", K);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [PW-1:0] x_sr;      // remaining dividend chunks, next chunk at the top
    logic [PW-1:0] q_sr;      // quotient digits shifted in LSB-first
    logic [RW-1:0] r;         // running remainder
    logic [CW-1:0] cnt;       // iteration index within the current division

    logic          start;     // capture a new operand this edge
    logic          step;      // perform one recurrence iteration this edge
    logic          last;      // current iteration is the final one

    logic [K-1:0]  chunk;
    logic [TW-1:0] t;
    logic [TW-1:0] div_res;
    logic [K-1:0]  digit;
    logic [RW-1:0] rem;
    logic [PW-1:0] q_next;

    // Restoring division of a value known to be below D*2^K by the constant D.
    // Each trial subtracts D*2^i; the invariant acc < D*2^(i+1) guarantees a
    // single-bit digit per position, so the K-bit result is exact. Returns
    // {digit, remainder}.
    function automatic logic [TW-1:0] div_const(input logic [TW-1:0] num);
        logic [TW-1:0] acc;
        logic [K-1:0]  dg;
        acc = num;
        dg  = '0;
        for (int i = K - 1; i >= 0; i--) begin
            if (acc >= (TW'(D) << i)) begin
                acc   = acc - (TW'(D) << i);
                dg[i] = 1'b1;
            end
        end
        return {dg, acc[RW-1:0]};
    endfunction

    // ---- recurrence datapath (combinational) ----
    always_comb begin
        chunk   = x_sr[PW-1 -: K];
        t       = {r, chunk};
        div_res = div_const(t);
        digit   = div_res[TW-1 -: K];
        rem     = div_res[RW-1:0];
        q_next  = (q_sr << K) | PW'(digit);
        last    = (cnt == CW'(NSTEP - 1));
    end

    // ---- control: state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- control: next state and handshake outputs ----
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        start      = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    start      = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        // Result leaves and the next operand enters together.
                        start      = 1'b1;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---- datapath registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            x_sr  <= '0;
            q_sr  <= '0;
            r     <= '0;
            cnt   <= '0;
            out_q <= '0;
            out_r <= '0;
        end else if (start) begin
            x_sr <= PW'(in_x);
            q_sr <= '0;
            r    <= '0;
            cnt  <= '0;
        end else if (step) begin
            x_sr <= x_sr << K;
            q_sr <= q_next;
            r    <= rem;
            cnt  <= cnt + 1'b1;
            if (last) begin
                // Quotient bits above QW are provably zero and dropped.
                out_q <= q_next[QW-1:0];
                out_r <= rem;
            end
        end
    end

endmodule

// File: tb/tb_const_div_iter.sv
// ---------------------------------------------------------------------------
// tb_const_div_iter
//
// Directed tests on the default configuration (W=64, D=23, K=4), the all-ones
// operand on K=5 and K=64 instances, and a randomized soak on nine D/K
// combinations running concurrently. Expected results come from plain
// x / D and x % D kept in per-instance queues.
// ---------------------------------------------------------------------------
module tb_const_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // ---------------- default instance (D=23, K=4) ----------------
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [59:0] out_q;
    logic [4:0]  out_r;

    const_div_iter #(.W(64), .D(23), .K(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r)
    );

    // ---------------- K=5 and K=64 instances ----------------
    logic        v5, rdy5, ov5, ordy5;
    logic [63:0] x5;
    logic [59:0] q5;
    logic [4:0]  r5;
    logic        v64, rdy64, ov64, ordy64;
    logic [63:0] x64;
    logic [59:0] q64;
    logic [4:0]  r64;

    const_div_iter #(.W(64), .D(23), .K(5)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(v5), .in_ready(rdy5), .in_x(x5),
        .out_valid(ov5), .out_ready(ordy5),
        .out_q(q5), .out_r(r5)
    );

    const_div_iter #(.W(64), .D(23), .K(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(v64), .in_ready(rdy64), .in_x(x64),
        .out_valid(ov64), .out_ready(ordy64),
        .out_q(q64), .out_r(r64)
    );

    // ---------------- random soak instances ----------------
    logic srst;
    int   soak_done_cnt = 0;

    for (genvar gi = 0; gi < 9; gi++) begin : g_soak
        localparam int SD   = (gi / 3 == 0) ? 3 : ((gi / 3 == 1) ? 23 : 1000);
        localparam int SK   = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 4 : 7);
        localparam int SQW  = 64 - $clog2(SD + 1) + 1;
        localparam int SRW  = $clog2(SD);
        localparam int NOPS = (SK == 1) ? 300 : 1200;

        logic           iv, ir, ov, ordy;
        logic [63:0]    ix;
        logic [SQW-1:0] oq;
        logic [SRW-1:0] orr;

        logic [63:0] exp_q[$];
        logic [63:0] exp_r[$];
        int          acc = 0;
        int          got = 0;

        const_div_iter #(.W(64), .D(SD), .K(SK)) u (
            .clk(clk), .rst(srst),
            .in_valid(iv), .in_ready(ir), .in_x(ix),
            .out_valid(ov), .out_ready(ordy),
            .out_q(oq), .out_r(orr)
        );

        // Driver: random offers and random consumer stalls, on the falling edge.
        initial begin
            int sel;
            iv   = 1'b0;
            ix   = '0;
            ordy = 1'b0;
            forever begin
                @(negedge clk);
                if (!srst) begin
                    iv  = (acc < NOPS) && ($urandom_range(0, 3) != 0);
                    sel = $urandom_range(0, 3);
                    case (sel)
                        0:       ix = 64'($urandom_range(0, 3 * SD));
                        1:       ix = ~64'($urandom_range(0, 3 * SD));
                        default: ix = {$urandom, $urandom};
                    endcase
                    ordy = ($urandom_range(0, 4) != 0);
                end
            end
        end

        // Checker: samples just after the falling edge, once inputs settle.
        initial begin
            logic           hold;
            logic [SQW-1:0] hq;
            logic [SRW-1:0] hr;
            logic [63:0]    eq, er;
            hold = 1'b0;
            hq   = '0;
            hr   = '0;
            forever begin
                @(negedge clk);
                #1;
                if (srst) begin
                    hold = 1'b0;
                end else begin
                    if (hold) begin
                        n_total++;
                        if (ov && oq == hq && orr == hr) n_pass++;
                        else $display("FAIL soak%0d hold: got v=%0d q=%0d r=%0d, want v=1 q=%0d r=%0d",
                                      gi, ov, oq, orr, hq, hr);
                    end
                    hold = ov && !ordy;
                    hq   = oq;
                    hr   = orr;
                    if (ov && ordy) begin
                        n_total++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL soak%0d extra result: got q=%0d r=%0d, want none", gi, oq, orr);
                        end else begin
                            eq = exp_q.pop_front();
                            er = exp_r.pop_front();
                            if (64'(oq) == eq && 64'(orr) == er) n_pass++;
                            else $display("FAIL soak%0d result: got q=%0d r=%0d, want q=%0d r=%0d",
                                          gi, oq, orr, eq, er);
                        end
                        got++;
                        if (got == NOPS) soak_done_cnt++;
                    end
                    if (iv && ir) begin
                        exp_q.push_back(ix / 64'(SD));
                        exp_r.push_back(ix % 64'(SD));
                        acc++;
                    end
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Called on the falling edge right after the accepting edge; counts the
    // falling edges until out_valid is seen (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input logic [63:0] x, input logic [63:0] eq, input logic [63:0] er,
                         input string nm);
        int lat;
        in_valid  = 1'b1;
        in_x      = x;
        out_ready = 1'b0;
        #1;
        check({nm, " in_ready idle"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_x     = 64'hA5A5_5A5A_DEAD_BEEF;
        wait_result(lat);
        check({nm, " latency"}, 64'(lat), 64'd16);
        check({nm, " q"}, 64'(out_q), eq);
        check({nm, " r"}, 64'(out_r), er);
        check({nm, " in_ready done stalled"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, " out_valid after consume"}, 64'(out_valid), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int l5, l64;
        int seen;
        rst = 1'b1; srst = 1'b1;
        in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
        v5 = 1'b0; x5 = '0; ordy5 = 1'b0;
        v64 = 1'b0; x64 = '0; ordy64 = 1'b0;
        repeat (3) @(negedge clk);

        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_q", 64'(out_q), 64'd0);
        check("reset out_r", 64'(out_r), 64'd0);
        rst = 1'b0; srst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", 64'(in_ready), 64'd1);

        do_op(64'd0,    64'd0,  64'd0,  "x0");
        do_op(64'd22,   64'd0,  64'd22, "x22");
        do_op(64'd23,   64'd1,  64'd0,  "x23");
        do_op(64'd1000, 64'd43, 64'd11, "x1000");
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd802032351030850070, 64'd5, "ones k4");

        // All-ones on K=5 (padded top chunk) and K=64 (single step).
        v5 = 1'b1; x5 = 64'hFFFF_FFFF_FFFF_FFFF;
        v64 = 1'b1; x64 = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        v5 = 1'b0; v64 = 1'b0;
        l5 = -1; l64 = -1;
        for (int n = 0; n < 100; n++) begin
            if (ov5 && l5 < 0) l5 = n;
            if (ov64 && l64 < 0) l64 = n;
            if (l5 >= 0 && l64 >= 0) break;
            @(negedge clk);
        end
        check("ones k5 latency", 64'(l5), 64'd13);
        check("ones k64 latency", 64'(l64), 64'd1);
        check("ones k5 q", 64'(q5), 64'd802032351030850070);
        check("ones k5 r", 64'(r5), 64'd5);
        check("ones k64 q", 64'(q64), 64'd802032351030850070);
        check("ones k64 r", 64'(r64), 64'd5);
        ordy5 = 1'b1; ordy64 = 1'b1;
        @(negedge clk);
        ordy5 = 1'b0; ordy64 = 1'b0;

        // Backpressure in DONE, then consume and accept on the same edge.
        in_valid = 1'b1; in_x = 64'd1000; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(lat);
        check("bp first latency", 64'(lat), 64'd16);
        for (int i = 0; i < 5; i++) begin
            check("bp out_valid held", 64'(out_valid), 64'd1);
            check("bp q held", 64'(out_q), 64'd43);
            check("bp r held", 64'(out_r), 64'd11);
            check("bp in_ready low", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_x = 64'd46;
        #1;
        check("bp in_ready follows out_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        check("bp out_valid dropped", 64'(out_valid), 64'd0);
        wait_result(lat);
        check("bp back-to-back latency", 64'(lat), 64'd16);
        check("bp x46 q", 64'(out_q), 64'd2);
        check("bp x46 r", 64'(out_r), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of RUN aborts the division.
        in_valid = 1'b1; in_x = 64'd12345678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort out_q", 64'(out_q), 64'd0);
        check("abort out_r", 64'(out_r), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("abort no result emitted", 64'(seen), 64'd0);
        do_op(64'd100, 64'd4, 64'd8, "x100 after abort");

        // Let the soak instances finish.
        lat = 0;
        while (soak_done_cnt < 9 && lat < 60000) begin
            @(negedge clk);
            lat++;
        end
        if (soak_done_cnt < 9) begin
            n_total++;
            $display("FAIL soak timeout: got %0d instances done, want 9", soak_done_cnt);
        end
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
